// File: rtl/reg_sequencer.sv
// Sequencer for the 4-bit calculator: turns one accepted command into per-cycle X/Y/Z opcodes and a ULA select.
// Latency from acceptance to done: NOP/illegal 1, CLR/MOVZ 2, ALU 4, shifts count+1; every output is registered.
// Backpressure: busy stays high through the DONE cycle, and start is ignored (not queued) while busy.
module reg_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] cmd,
    input  logic [1:0] op_sel,
    input  logic [1:0] count,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] tx,
    output logic [3:0] ty,
    output logic [3:0] tz,
    output logic [1:0] ula_sel
);
    localparam logic [3:0] HOLD   = 4'd0;
    localparam logic [3:0] LOAD   = 4'd1;
    localparam logic [3:0] SHIFTR = 4'd2;
    localparam logic [3:0] SHIFTL = 4'd3;
    localparam logic [3:0] CLEAR  = 4'd4;

    typedef enum logic [2:0] {IDLE, LDX, LDY, LDZ, CLR, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] op_q, op_nxt;
    logic       shl_q, shl_nxt;
    logic       busy_nxt, done_nxt, err_nxt;
    logic [3:0] tx_nxt, ty_nxt, tz_nxt;
    logic [1:0] ula_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            op_q    <= 2'd0;
            shl_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            tx      <= HOLD;
            ty      <= HOLD;
            tz      <= HOLD;
            ula_sel <= 2'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_q    <= op_nxt;
            shl_q   <= shl_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            tx      <= tx_nxt;
            ty      <= ty_nxt;
            tz      <= tz_nxt;
            ula_sel <= ula_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        shl_nxt   = shl_q;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt  = op_sel;
                    cnt_nxt = count;
                    shl_nxt = (cmd == 3'b100);
                    case (cmd)
                        3'b000:         state_nxt = DONE;
                        3'b001:         state_nxt = CLR;
                        3'b010:         state_nxt = LDX;
                        3'b011, 3'b100: state_nxt = (count == 2'd0) ? DONE : SHIFT;
                        3'b101:         state_nxt = LDZ;
                        default: begin
                            state_nxt = DONE;
                            err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            LDX:  state_nxt = LDY;
            LDY:  state_nxt = LDZ;
            LDZ:  state_nxt = DONE;
            CLR:  state_nxt = DONE;
            SHIFT: begin
                // Leave once the decremented count reaches zero: exactly count shift cycles.
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        tx_nxt   = HOLD;
        ty_nxt   = HOLD;
        tz_nxt   = HOLD;
        ula_nxt  = 2'd0;
        case (state_nxt)
            LDX:   tx_nxt = LOAD;
            LDY: begin
                ty_nxt  = LOAD;
                ula_nxt = op_nxt;
            end
            LDZ:   tz_nxt = LOAD;
            CLR: begin
                tx_nxt = CLEAR;
                ty_nxt = CLEAR;
                tz_nxt = CLEAR;
            end
            SHIFT: tz_nxt = shl_nxt ? SHIFTL : SHIFTR;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: directed literal checks plus 200 random commands against a command-level trace model
// and a negedge-clocked X/Y/Z datapath whose Z is checked at every done.
module tb_reg_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic [1:0] op_sel = 2'd0;
    logic [1:0] count = 2'd0;
    logic       busy, done, err;
    logic [3:0] tx, ty, tz;
    logic [1:0] ula_sel;
    logic [3:0] din = 4'd0;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    reg_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .op_sel(op_sel), .count(count),
        .busy(busy), .done(done), .err(err), .tx(tx), .ty(ty), .tz(tz), .ula_sel(ula_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] tx;
        logic [3:0] ty;
        logic [3:0] tz;
        logic [1:0] ula;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] ula_f(input logic [3:0] x, input logic [3:0] y, input logic [1:0] s);
        case (s)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return x & y;
            default: return x ^ y;
        endcase
    endfunction

    function automatic logic [3:0] apply(input logic [3:0] op, input logic [3:0] cur, input logic [3:0] ld);
        case (op)
            4'd1:    return ld;
            4'd2:    return cur >> 1;
            4'd3:    return cur << 1;
            4'd4:    return 4'd0;
            default: return cur;
        endcase
    endfunction

    function automatic exp_t mk(input bit d, input bit e, input logic [3:0] x, input logic [3:0] y,
                                input logic [3:0] z, input logic [1:0] u);
        return {1'b1, d, e, x, y, z, u};
    endfunction

    // Datapath plant driven by the DUT outputs, sampling on the falling edge.
    logic [3:0] px = 4'd0, py = 4'd0, pz = 4'd0;
    always @(negedge clk) begin
        px <= apply(tx, px, din);
        py <= apply(ty, py, ula_f(px, py, ula_sel));
        pz <= apply(tz, pz, py);
    end

    // Command-level model: expected per-cycle output trace and expected X/Y/Z after each command.
    exp_t       q[$];
    exp_t       cur = '0;
    logic [3:0] mx = 4'd0, my = 4'd0, mz = 4'd0;
    logic [3:0] zexp = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else if (!cur.busy && start) begin
            case (cmd)
                3'd0: ;
                3'd1: begin
                    q.push_back(mk(0, 0, 4, 4, 4, 0));
                    mx = 0; my = 0; mz = 0;
                end
                3'd2: begin
                    q.push_back(mk(0, 0, 1, 0, 0, 0));
                    q.push_back(mk(0, 0, 0, 1, 0, op_sel));
                    q.push_back(mk(0, 0, 0, 0, 1, 0));
                    mx = din; my = ula_f(mx, my, op_sel); mz = my;
                end
                3'd3, 3'd4: begin
                    for (int i = 0; i < int'(count); i++)
                        q.push_back(mk(0, 0, 0, 0, (cmd == 3'd3) ? 4'd2 : 4'd3, 0));
                    mz = (cmd == 3'd3) ? (mz >> count) : (mz << count);
                end
                3'd5: begin
                    q.push_back(mk(0, 0, 0, 0, 1, 0));
                    mz = my;
                end
                default: ;
            endcase
            q.push_back(mk(1, (cmd > 3'd5), 0, 0, 0, 0));
            zexp = mz;
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = '0;
        end
    end

    exp_t act_t;
    assign act_t = {busy, done, err, tx, ty, tz, ula_sel};

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("outputs", act_t, cur);
            if (cur.done) chk("z_after_cmd", pz, zexp);
        end
    end

    task automatic wait_idle(input bit noise);
        int n = 0;
        while (busy && n < 20) begin
            if (noise) begin
                start  = ($urandom_range(0, 3) == 0);
                cmd    = 3'($urandom);
                op_sel = 2'($urandom);
                count  = 2'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("wait_idle", busy, 0);
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] o, input logic [1:0] n, input logic [3:0] d);
        start = 1'b1; cmd = c; op_sel = o; count = n; din = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int shifts, lat, dones;
        repeat (2) @(negedge clk);
        chk("reset_outputs", act_t, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // ALU with op_sel=2
        issue(3'b010, 2'b10, 2'd0, 4'd9);
        chk("alu_c1", {tx, ty, tz, ula_sel}, {4'd1, 4'd0, 4'd0, 2'd0});
        @(negedge clk);
        chk("alu_c2", {tx, ty, tz, ula_sel}, {4'd0, 4'd1, 4'd0, 2'd2});
        @(negedge clk);
        chk("alu_c3", {tx, ty, tz, ula_sel}, {4'd0, 4'd0, 4'd1, 2'd0});
        @(negedge clk);
        chk("alu_c4_done", {busy, done}, 2'b11);
        @(negedge clk);
        chk("alu_c5_busy", busy, 0);

        // Reset in LDY aborts immediately
        issue(3'b010, 2'b01, 2'd0, 4'd3);
        @(posedge clk);
        #1;
        chk("in_ldy", ty, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_ldy", act_t, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b001, 2'd0, 2'd0, 4'd7);
        chk("clr_c1", {tx, ty, tz}, {4'd4, 4'd4, 4'd4});
        @(negedge clk);
        chk("clr_c2", {done, tx, ty, tz}, {1'b1, 12'd0});
        wait_idle(0);

        // SHR count=3: exactly three SHIFTR cycles, done at count+1
        issue(3'b100, 2'd0, 2'd0, 4'd0);
        wait_idle(0);
        issue(3'b010, 2'd0, 2'd0, 4'd11);
        wait_idle(0);
        issue(3'b011, 2'd0, 2'd3, 4'd11);
        shifts = 0; lat = 1;
        while (!done && lat < 10) begin
            if (tz == 4'd2) shifts++;
            @(negedge clk);
            lat++;
        end
        chk("shr_cycles", shifts, 3);
        chk("shr_latency", lat, 4);
        wait_idle(0);

        issue(3'b100, 2'd0, 2'd0, 4'd0);
        chk("shl0_done", {done, tz}, {1'b1, 4'd0});
        wait_idle(0);

        issue(3'b111, 2'd3, 2'd3, 4'd0);
        chk("illegal_c1", {done, err, tx, ty, tz}, {2'b11, 12'd0});
        @(negedge clk);
        chk("illegal_c2", {done, err}, 2'b00);
        wait_idle(0);

        // start pulsed while busy is ignored
        issue(3'b010, 2'b11, 2'd0, 4'd6);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            start = (i < 2);
            cmd = 3'b001;
            if (done) dones++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_start_ignored", dones, 1);
        wait_idle(0);

        // start held high: NOP re-accepted every 2 cycles
        start = 1'b1; cmd = 3'b000;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        chk("held_start_nops", dones, 6);
        @(negedge clk);
        wait_idle(0);

        for (int k = 0; k < 200; k++) begin
            wait_idle(1);
            issue(3'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
        end
        wait_idle(0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
